// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Purpose:
//   Receives a program as a byte stream over a valid/ready handshake and
//   writes it into instruction memory as 16-bit words.  The stream is a
//   little-endian 16-bit word count followed by that many words, each sent
//   low byte first.  The CPU is held for the whole session, and the session
//   ends in DONE (success) or ERR (abort).
//
// Optional feature:
//   PROG_LOADER_CHKSUM_EN -- when defined, one extra byte follows the data.
//   It must equal the XOR of all data bytes (header excluded), otherwise the
//   session ends in ERR.  When undefined, the check state and the checksum
//   register do not exist.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous reset, active-low
//   start       in   one-cycle request to begin a session (IDLE/DONE/ERR only)
//   byte_in     in   [7:0] incoming program byte
//   byte_valid  in   byte_in valid
//   byte_ready  out  loader accepts byte_in this cycle
//   imem_we     out  instruction-memory write strobe, one cycle per word
//   imem_addr   out  [ADDR_W-1:0] write address (word index)
//   imem_wdata  out  [15:0] instruction word {hi, lo}
//   cpu_hold    out  holds the CPU while a session is active or failed
//   done        out  session completed (level, until next start/reset)
//   error       out  session aborted (level, until next start/reset)
//   word_count  out  [15:0] word count from the most recent header
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_LO  = 3'd1,
      S_LEN_HI  = 3'd2,
      S_DATA_LO = 3'd3,
      S_DATA_HI = 3'd4,
`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK     = 3'd5,
`endif
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                w_byte_ready;
   logic                w_cpu_hold;
   logic                w_done;
   logic                w_error;
   logic                w_accept;
   logic                w_start_ok;
   logic [15:0]         w_hdr_count;
   logic                w_too_long;
   logic                w_last_word;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_wdata;
   logic [7:0]          r_lo;
   logic [15:0]         r_word_count;
   logic [15:0]         r_words_done;
`ifdef PROG_LOADER_CHKSUM_EN
   logic [7:0]          r_chk;
`endif

   // Handshake and session-level decodes
   assign w_accept    = byte_valid & w_byte_ready;
   assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                 (r_state == S_ERR));
   // Full header value as it becomes known on the LEN_HI accept
   assign w_hdr_count = {byte_in, r_word_count[7:0]};
   assign w_too_long  = ({16'd0, w_hdr_count} > DEPTH);
   assign w_last_word = ((r_words_done + 16'd1) == r_word_count);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_byte_ready = 1'b0;
      w_cpu_hold   = 1'b1;
      w_done       = 1'b0;
      w_error      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cpu_hold = 1'b0;
            if (start) w_state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            w_byte_ready = 1'b1;
            if (byte_valid) w_state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            w_byte_ready = 1'b1;
            if (byte_valid) begin
               if (w_too_long) begin
                  w_state_nxt = S_ERR;
               end else if (w_hdr_count == 16'd0) begin
`ifdef PROG_LOADER_CHKSUM_EN
                  w_state_nxt = S_CHK;
`else
                  w_state_nxt = S_DONE;
`endif
               end else begin
                  w_state_nxt = S_DATA_LO;
               end
            end
         end
         S_DATA_LO: begin
            w_byte_ready = 1'b1;
            if (byte_valid) w_state_nxt = S_DATA_HI;
         end
         S_DATA_HI: begin
            w_byte_ready = 1'b1;
            if (byte_valid) begin
               if (w_last_word) begin
`ifdef PROG_LOADER_CHKSUM_EN
                  w_state_nxt = S_CHK;
`else
                  w_state_nxt = S_DONE;
`endif
               end else begin
                  w_state_nxt = S_DATA_LO;
               end
            end
         end
`ifdef PROG_LOADER_CHKSUM_EN
         S_CHK: begin
            w_byte_ready = 1'b1;
            if (byte_valid) begin
               w_state_nxt = (byte_in == r_chk) ? S_DONE : S_ERR;
            end
         end
`endif
         S_DONE: begin
            w_cpu_hold = 1'b0;
            w_done     = 1'b1;
            if (start) w_state_nxt = S_LEN_LO;
         end
         S_ERR: begin
            w_error = 1'b1;
            if (start) w_state_nxt = S_LEN_LO;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: header capture, word assembly, write strobe and address
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 16'd0;
         r_lo         <= 8'd0;
         r_word_count <= 16'd0;
         r_words_done <= 16'd0;
`ifdef PROG_LOADER_CHKSUM_EN
         r_chk        <= 8'd0;
`endif
      end else begin
         r_we <= 1'b0;

         if (w_start_ok) begin
            r_addr       <= '0;
            r_words_done <= 16'd0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_chk        <= 8'd0;
`endif
         end

         // Address advances at the end of the write cycle; after the last
         // word the FSM has already left DATA_LO, so the address stops on
         // the final index instead of wrapping past DEPTH-1.
         if (r_we && (r_state == S_DATA_LO)) begin
            r_addr <= r_addr + ADDR_W'(1);
         end

         if (w_accept) begin
            case (r_state)
               S_LEN_LO: r_word_count[7:0]  <= byte_in;
               S_LEN_HI: r_word_count[15:8] <= byte_in;
               S_DATA_LO: begin
                  r_lo  <= byte_in;
`ifdef PROG_LOADER_CHKSUM_EN
                  r_chk <= r_chk ^ byte_in;
`endif
               end
               S_DATA_HI: begin
                  r_wdata      <= {byte_in, r_lo};
                  r_we         <= 1'b1;
                  r_words_done <= r_words_done + 16'd1;
`ifdef PROG_LOADER_CHKSUM_EN
                  r_chk        <= r_chk ^ byte_in;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign byte_ready = w_byte_ready;
   assign cpu_hold   = w_cpu_hold;
   assign done       = w_done;
   assign error      = w_error;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign word_count = r_word_count;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 byte_in  input  8  incoming program byte.
REQ-006 byte_valid  input  1  byte_in valid.
REQ-007 byte_ready  output  1  loader accepts byte_in; transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  write address.
REQ-010 imem_wdata  output  16  instruction word written.
REQ-011 cpu_hold  output  1  holds the CPU (PC and register/memory write enables) while loading.
REQ-012 done  output  1  session completed successfully; level.
REQ-013 error  output  1  session aborted; level.
REQ-014 word_count  output  16  word count received in the header.

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK (macro only), DONE, ERR.
REQ-016 byte_ready SHALL be 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK, and 0 in IDLE, DONE and ERR.
REQ-017 start in IDLE, DONE or ERR -> LEN_LO next cycle; done, error and the byte checksum cleared; imem_addr set to 0; start is ignored in every other state.
REQ-018 Header: first accepted byte = word_count[7:0], second = word_count[15:8] (little-endian).
REQ-019 After LEN_HI accept: count > DEPTH -> ERR; count == 0 -> DONE (or CHK with macro); otherwise -> DATA_LO.
REQ-020 Each word = low byte then high byte; imem_wdata = {hi, lo}.
REQ-021 imem_we SHALL be 1 for exactly the cycle after the DATA_HI accept, with imem_addr = word index k (0-based) and imem_wdata stable in that cycle.
REQ-022 imem_addr increments after each write; it never wraps, because count <= DEPTH is enforced.
REQ-023 After the Nth word's high byte: -> DONE (or CHK with macro); otherwise -> DATA_LO.
REQ-024 Cycles with byte_valid = 0 SHALL stall in the current state with no timeout; there are no bubbles beyond the handshake.
REQ-025 cpu_hold SHALL be 1 in every state except IDLE and DONE.
REQ-026 done = 1 only in DONE; error = 1 only in ERR; both hold until the next start or reset.
REQ-027 word_count holds its last header value until the next session overwrites it.

Reset
REQ-028 With rst_n = 0 at a clock edge: state = IDLE; byte_ready, imem_we, cpu_hold, done and error = 0; imem_addr, imem_wdata, word_count and the checksum = 0.
REQ-029 Reset mid-session SHALL abandon the session immediately; words already written are not rolled back.

Configuration
REQ-030 Macro PROG_LOADER_CHKSUM_EN defined: after the last data byte (or after the header when count = 0), CHK accepts one byte; a match with the XOR of all data bytes -> DONE, a mismatch -> ERR; header bytes are excluded from the XOR.
REQ-031 Macro PROG_LOADER_CHKSUM_EN undefined: the CHK state and checksum register are absent, and the transitions go directly to DONE.

Verification
REQ-032 Reset, then start, then bytes 02 00 34 12 CD AB -> writes addr0 = 0x1234 and addr1 = 0xABCD, one imem_we pulse each; done = 1 the cycle after the last accept; cpu_hold 1 -> 0.
REQ-033 Header 00 00 -> no imem_we; done next cycle (macro off); word_count = 0.
REQ-034 Header 01 01 with ADDR_W = 8 (count 257 > 256) -> error = 1, cpu_hold = 1, byte_ready = 0, no writes.
REQ-035 byte_valid toggled 1/0 each cycle during a 3-word load -> identical memory contents, and imem_we pulses only after high-byte accepts.
REQ-036 Macro on: 01 00 34 12 26 -> done (0x34 ^ 0x12 = 0x26); the same stimulus with final byte 00 -> error = 1.
REQ-037 rst_n = 0 between the low and high byte of word 1 -> IDLE, all outputs at reset values; a following start and a full session complete normally; start pulsed mid-session is ignored.
